axi_mem_slave: RTL and testbench
================================

Name: axi_mem_slave

Overview:
Parametrised AXI4 slave that bridges one AXI port to a single-port synchronous SRAM/ROM macro with 1-cycle read latency.
- Supports read and write bursts of type FIXED, INCR and WRAP, with byte strobes and read/write arbitration.
- Successor to the fixed-size read-only ROM bridge; instantiated once per memory (ROM, IM, DM) on the AXI bus.

Parameters:
ADDR_W, 14, number of byte-address bits decoded; memory word address is araddr/awaddr[ADDR_W-1:2]
DATA_W, 32, data width in bits; must be 32 or 64
ID_W, 8, AXI slave-side ID width
LEN_W, 4, AXI burst length field width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/32/LEN_W/3/2/1  read address channel
arready  out  1  read address ready
rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel
rready  in  1  read data ready
awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/32/LEN_W/3/2/1  write address channel
awready  out  1  write address ready
wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data channel
wready  out  1  write data ready
bid/bresp/bvalid  out  ID_W/2/1  write response channel
bready  in  1  write response ready
mem_cs  out  1  memory chip select
mem_we  out  DATA_W/8  per-byte write enable, active-high
mem_addr  out  ADDR_W-2+log2(32/DATA_W)  word address (ADDR_W-2 for DATA_W=32)
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data; reflects mem_addr of the previous cycle when mem_cs=1

Behaviour:
- FSM states: IDLE, R_CH, W_CH, B_CH. Reset state is IDLE.
- Reset state of outputs: all registers clear; rvalid, bvalid, wready, mem_we = 0.
- arready = (IDLE) & ~(awvalid & ~rd_prio).
- awready = (IDLE) & ~(arvalid & rd_prio).
- rd_prio resets to 1 and toggles after every granted transaction to the opposite channel (round-robin when both are valid).
- IDLE -> R_CH on AR handshake: latch arid, arlen, arburst, and the word address. mem_addr = araddr word bits combinationally and mem_cs = 1, so rdata is valid on the first R_CH cycle (1-cycle AR-to-R latency).
- R_CH:
  - rvalid = 1; rdata = mem_rdata; rid = latched id; rresp = OKAY; rlast = (beat_cnt == len).
  - mem_cs = 1; mem_addr = next_addr if R handshake this cycle, else cur_addr. Stalled data is therefore re-read and held stable.
  - On R handshake: beat_cnt += 1 and cur_addr = next_addr.
  - On R handshake with rlast: clear beat_cnt and go to IDLE. No AR acceptance in R_CH.
- IDLE -> W_CH on AW handshake: latch awid, awlen, awburst, and the word address.
- W_CH:
  - wready = 1.
  - On W handshake: mem_cs = 1, mem_we = wstrb, mem_addr = cur_addr, mem_wdata = wdata; advance address and counter.
  - When beat_cnt == len on a handshake, go to B_CH regardless of wlast.
  - Record an error flag if wlast != (beat_cnt == len) on any beat.
- B_CH: bvalid = 1; bid = latched id; bresp = SLVERR if error flag set, else OKAY. On bready, clear the flag and go to IDLE.
- Address advance on word address A with latched len L:
  - FIXED: next_addr = A.
  - INCR: next_addr = A+1, wrapping modulo memory size (no overflow into upper bits).
  - WRAP: next_addr = (A & ~L) | ((A+1) & L); valid only for L in {1,3,7,15}.
  - Other L values or reserved burst type 2'b11: treated as INCR.
- araddr/awaddr bits above ADDR_W are ignored. arsize/awsize are ignored (full-width beats).
- mem_cs = 0 in B_CH and in IDLE without a handshake.
- Simultaneous arvalid and awvalid in IDLE: exactly one ready is asserted, per rd_prio.
- Reset mid-burst: FSM returns to IDLE immediately and outputs drop. The partial burst is not completed.

Optional Feature:
AXI_MEM_RO_EN:
- Defined: read-only mode. AW and W are still accepted (protocol-complete), but mem_we is forced to 0 and mem_cs is not asserted for write beats. bresp = SLVERR for every write burst.
- Undefined: full read/write as above.

Test Plan:
- Single read: araddr=0x10, arlen=0, arid=3, mem word 4=0xDEADBEEF -> one cycle after AR handshake rvalid=1, rdata=0xDEADBEEF, rid=3, rlast=1.
- INCR read: arlen=3 from word 8, rready toggles 1/0 -> beats return words 8,9,10,11; data is held stable during stalls; rlast only on 4th beat.
- WRAP read: arlen=3, start word 6 -> beats 6,7,4,5.
- Write burst: awlen=1, word 2, wstrb=4'b0011 then 4'b1111 -> mem_we pulses match the strobes; memory shows partial/full bytes; bresp=OKAY, bid matches awid.
- Contention and wlast error:
  - Case 1: arvalid and awvalid asserted together after reset -> read granted first, write next.
  - Case 2: wlast asserted early on beat 0 of awlen=1 -> bresp=SLVERR.
- With AXI_MEM_RO_EN: write burst -> mem_we stays 0, memory unchanged, bresp=SLVERR; reads unaffected.

Source files
------------

// File: rtl/axi_mem_slave.sv
// AXI4 slave bridging one AXI port to a single-port synchronous SRAM/ROM with 1-cycle read latency.
// Define AXI_MEM_RO_EN for read-only mode (writes accepted but discarded, bresp = SLVERR).
module axi_mem_slave #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4,
    parameter int OFF_W  = $clog2(DATA_W / 8),
    parameter int MA_W   = ADDR_W - OFF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     arid,
    input  logic [31:0]         araddr,
    input  logic [LEN_W-1:0]    arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_W-1:0]     awid,
    input  logic [31:0]         awaddr,
    input  logic [LEN_W-1:0]    awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    output logic                mem_cs,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [MA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, R_CH = 2'd1, W_CH = 2'd2, B_CH = 2'd3} state_e;

    state_e            state_q, state_d;
    logic              rd_prio_q, rd_prio_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        burst_q, burst_d;
    logic [MA_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic [MA_W-1:0]   next_addr;
    logic [MA_W-1:0]   len_mask;
    logic              wrap_ok;
    logic              is_last;
    logic              ar_hs, aw_hs;
    logic              unused_bits;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never depends on ready, and ready here depends only on state and the competing valid.
    assign arready = (state_q == IDLE) & ~(awvalid & ~rd_prio_q);
    assign awready = (state_q == IDLE) & ~(arvalid & rd_prio_q);
    assign ar_hs   = arvalid & arready;
    assign aw_hs   = awvalid & awready;

    assign is_last     = (beat_cnt_q == len_q);
    assign len_mask    = MA_W'(len_q);
    assign wrap_ok     = (len_q == LEN_W'(1)) || (len_q == LEN_W'(3)) ||
                         (len_q == LEN_W'(7)) || (len_q == LEN_W'(15));
    assign dbg_state_o = state_q;

`ifdef AXI_MEM_RO_EN
    assign unused_bits = ^{arsize, awsize, araddr[31:ADDR_W], araddr[OFF_W-1:0],
                           awaddr[31:ADDR_W], awaddr[OFF_W-1:0], wstrb};
`else
    assign unused_bits = ^{arsize, awsize, araddr[31:ADDR_W], araddr[OFF_W-1:0],
                           awaddr[31:ADDR_W], awaddr[OFF_W-1:0]};
`endif

    // INCR wraps naturally at the memory size because the address is exactly MA_W bits wide.
    always_comb begin
        next_addr = cur_addr_q + MA_W'(1);
        case (burst_q)
            2'b00:   next_addr = cur_addr_q;
            2'b10:   if (wrap_ok) next_addr = (cur_addr_q & ~len_mask) |
                                              ((cur_addr_q + MA_W'(1)) & len_mask);
            default: next_addr = cur_addr_q + MA_W'(1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_prio_d  = rd_prio_q;
        id_d       = id_q;
        len_d      = len_q;
        burst_d    = burst_q;
        cur_addr_d = cur_addr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        rvalid     = 1'b0;
        rid        = id_q;
        rdata      = mem_rdata;
        rresp      = RESP_OKAY;
        rlast      = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bid        = id_q;
        bresp      = RESP_OKAY;
        mem_cs     = 1'b0;
        mem_we     = '0;
        mem_addr   = cur_addr_q;
        mem_wdata  = wdata;

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    // Launch the first read now so data is ready on the first R_CH cycle.
                    state_d    = R_CH;
                    id_d       = arid;
                    len_d      = arlen;
                    burst_d    = arburst;
                    cur_addr_d = araddr[ADDR_W-1:OFF_W];
                    beat_cnt_d = '0;
                    rd_prio_d  = 1'b0;
                    mem_cs     = 1'b1;
                    mem_addr   = araddr[ADDR_W-1:OFF_W];
                end else if (aw_hs) begin
                    state_d    = W_CH;
                    id_d       = awid;
                    len_d      = awlen;
                    burst_d    = awburst;
                    cur_addr_d = awaddr[ADDR_W-1:OFF_W];
                    beat_cnt_d = '0;
                    rd_prio_d  = 1'b1;
                end
            end
            R_CH: begin
                rvalid = 1'b1;
                rlast  = is_last;
                mem_cs = 1'b1;
                if (rready) begin
                    mem_addr   = next_addr;
                    cur_addr_d = next_addr;
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (is_last) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            W_CH: begin
                wready = 1'b1;
                if (wvalid) begin
`ifdef AXI_MEM_RO_EN
                    mem_cs = 1'b0;
                    mem_we = '0;
`else
                    mem_cs = 1'b1;
                    mem_we = wstrb;
`endif
                    cur_addr_d = next_addr;
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (wlast != is_last) err_d = 1'b1;
                    if (is_last) begin
                        beat_cnt_d = '0;
                        state_d    = B_CH;
                    end
                end
            end
            B_CH: begin
                bvalid = 1'b1;
`ifdef AXI_MEM_RO_EN
                bresp = RESP_SLVERR;
`else
                bresp = err_q ? RESP_SLVERR : RESP_OKAY;
`endif
                if (bready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_prio_q  <= 1'b1;
            id_q       <= '0;
            len_q      <= '0;
            burst_q    <= '0;
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_prio_q  <= rd_prio_d;
            id_q       <= id_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            cur_addr_q <= cur_addr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave: SRAM macro model plus an independent word-array reference
// whose burst address sequences are computed arithmetically.
module tb_axi_mem_slave;

    localparam int WORDS = 4096;

    logic        clk, rst;
    logic [7:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata, mem_wdata, mem_rdata;
    logic [3:0]  arlen, awlen, wstrb, mem_we;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp, dbg_state;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, mem_cs;
    logic [11:0] mem_addr;

    logic [31:0] sram    [WORDS];
    logic [31:0] ref_mem [WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    axi_mem_slave dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port memory macro, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_cs) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= sram[mem_addr];
        end
    end

    // reference: word address of beat i of a burst
    function automatic int beat_addr(input int start, input int len, input int burst, input int i);
        int n, base;
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            n    = len + 1;
            base = (start / n) * n;
            return base + (start - base + i) % n;
        end
        return (start + i) % WORDS;
    endfunction

    function automatic logic [1:0] exp_bresp(input bit err);
`ifdef AXI_MEM_RO_EN
        return 2'b10;
`else
        return err ? 2'b10 : 2'b00;
`endif
    endfunction

    // driver tasks (entered at a falling edge, return at a falling edge)
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        int t;
        t = 0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        #1;
        while (arready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
        n_checks++;
        if (arready !== 1'b1) $display("FAIL ar_accept: arready=%b after %0d cycles, want 1", arready, t);
        else n_pass++;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        int t;
        t = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
        #1;
        while (awready !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
        n_checks++;
        if (awready !== 1'b1) $display("FAIL aw_accept: awready=%b after %0d cycles, want 1", awready, t);
        else n_pass++;
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    // mode 0: always ready, 1: rready toggles 1/0, 2: random with bounded stalls
    task automatic recv_r(input logic [7:0] id, input int start, input int len,
                          input int burst, input int mode);
        int cyc, stalls;
        logic [31:0] exp_d;
        cyc = 0;
        for (int i = 0; i <= len; i++) begin
            exp_d  = ref_mem[beat_addr(start, len, burst, i)];
            stalls = 0;
            forever begin
                if (mode == 0) rready = 1'b1;
                else if (mode == 1) rready = (cyc % 2 == 0);
                else rready = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
                cyc++;
                #1;
                n_checks++;
                if (rvalid !== 1'b1 || rdata !== exp_d || rid !== id ||
                    rlast !== (i == len) || rresp !== 2'b00)
                    $display("FAIL r_beat%0d: got v=%b d=%h id=%h last=%b resp=%0d, want v=1 d=%h id=%h last=%b resp=0",
                             i, rvalid, rdata, rid, rlast, rresp, exp_d, id, (i == len));
                else n_pass++;
                @(negedge clk);
                if (rready) break;
                stalls++;
            end
        end
        rready = 1'b0;
    endtask

    task automatic send_w(input int start, input int len, input int burst, input int err_beat,
                          input bit fixed_strb, output bit got_err);
        logic [3:0]  s;
        logic [31:0] d;
        logic [11:0] ea;
        int a;
        got_err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            while ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
            s  = fixed_strb ? ((i == 0) ? 4'b0011 : 4'b1111) : 4'($urandom_range(0, 15));
            d  = $urandom;
            a  = beat_addr(start, len, burst, i);
            ea = 12'(a);
            wvalid = 1'b1; wdata = d; wstrb = s;
            wlast  = (i == len) ^ (i == err_beat);
            if (i == err_beat) got_err = 1'b1;
            #1;
            n_checks++;
`ifdef AXI_MEM_RO_EN
            if (wready !== 1'b1 || mem_cs !== 1'b0 || mem_we !== 4'b0000)
                $display("FAIL w_beat%0d: got wready=%b cs=%b we=%b, want wready=1 cs=0 we=0000",
                         i, wready, mem_cs, mem_we);
            else n_pass++;
`else
            if (wready !== 1'b1 || mem_cs !== 1'b1 || mem_we !== s || mem_addr !== ea || mem_wdata !== d)
                $display("FAIL w_beat%0d: got wready=%b cs=%b we=%b addr=%h wd=%h, want 1 1 %b %h %h",
                         i, wready, mem_cs, mem_we, mem_addr, mem_wdata, s, ea, d);
            else n_pass++;
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
`endif
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic recv_b(input logic [7:0] id, input logic [1:0] resp);
        int t;
        t = 0;
        forever begin
            bready = (t >= 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
            #1;
            n_checks++;
            if (bvalid !== 1'b1 || bid !== id || bresp !== resp || mem_cs !== 1'b0)
                $display("FAIL b_resp: got v=%b id=%h resp=%0d cs=%b, want v=1 id=%h resp=%0d cs=0",
                         bvalid, bid, bresp, mem_cs, id, resp);
            else n_pass++;
            @(negedge clk);
            if (bready) break;
            t++;
        end
        bready = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || wready !== 1'b0 || mem_we !== 4'b0 || mem_cs !== 1'b0)
            $display("FAIL reset_outputs: rvalid=%b bvalid=%b wready=%b we=%b cs=%b, want all 0",
                     rvalid, bvalid, wready, mem_we, mem_cs);
        else n_pass++;
        n_checks++;
        if (arready !== 1'b1 || awready !== 1'b1 || dbg_state !== 2'd0)
            $display("FAIL reset_idle: arready=%b awready=%b state=%0d, want 1 1 0", arready, awready, dbg_state);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        sram[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        send_ar(8'd3, 32'h10, 4'd0, 2'b01);
        recv_r(8'd3, 4, 0, 1, 0);
    endtask

    task automatic test_incr_read();
        send_ar(8'h5A, 32'h20, 4'd3, 2'b01);
        recv_r(8'h5A, 8, 3, 1, 1);
    endtask

    task automatic test_wrap_read();
        send_ar(8'h77, 32'h18, 4'd3, 2'b10);
        recv_r(8'h77, 6, 3, 2, 2);
    endtask

    task automatic test_write_burst();
        bit e;
        send_aw(8'hA1, 32'h8, 4'd1, 2'b01);
        send_w(2, 1, 1, -1, 1'b1, e);
        recv_b(8'hA1, exp_bresp(e));
        send_ar(8'hA2, 32'h8, 4'd1, 2'b01);
        recv_r(8'hA2, 2, 1, 1, 0);
    endtask

    task automatic test_contention();
        bit e;
        do_reset();
        arid = 8'h11; araddr = 32'h40; arlen = 4'd0; arburst = 2'b01; arsize = 3'd2;
        awid = 8'h22; awaddr = 32'h80; awlen = 4'd0; awburst = 2'b01; awsize = 3'd2;
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        n_checks++;
        if (arready !== 1'b1 || awready !== 1'b0)
            $display("FAIL arb_read_first: arready=%b awready=%b, want 1 0", arready, awready);
        else n_pass++;
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        n_checks++;
        if (awready !== 1'b0) $display("FAIL aw_blocked_in_read: awready=%b, want 0", awready);
        else n_pass++;
        recv_r(8'h11, 16, 0, 1, 0);
        arvalid = 1'b1;
        #1;
        n_checks++;
        if (awready !== 1'b1 || arready !== 1'b0)
            $display("FAIL arb_write_next: arready=%b awready=%b, want 0 1", arready, awready);
        else n_pass++;
        send_aw(8'h22, 32'h80, 4'd0, 2'b01);
        send_w(32, 0, 1, -1, 1'b0, e);
        recv_b(8'h22, exp_bresp(e));
        send_ar(8'h11, 32'h40, 4'd0, 2'b01);
        recv_r(8'h11, 16, 0, 1, 0);
    endtask

    task automatic test_wlast_err();
        bit e;
        send_aw(8'h3C, 32'h100, 4'd1, 2'b01);
        send_w(64, 1, 1, 0, 1'b0, e);
        recv_b(8'h3C, 2'b10);
    endtask

    task automatic test_reset_mid_burst();
        send_ar(8'h44, 32'h190, 4'd7, 2'b01);
        rready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (rvalid !== 1'b0 || mem_cs !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL reset_mid_burst: rvalid=%b cs=%b state=%0d, want 0 0 0", rvalid, mem_cs, dbg_state);
        else n_pass++;
        rready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_ar(8'h45, 32'h194, 4'd0, 2'b01);
        recv_r(8'h45, 101, 0, 1, 0);
    endtask

    task automatic test_random();
        bit e;
        int start, len, burst, err_beat;
        logic [7:0] id;
        logic [31:0] addr;
        repeat (40) begin
            start = $urandom_range(0, WORDS - 1);
            len   = $urandom_range(0, 15);
            burst = $urandom_range(0, 3);
            id    = 8'($urandom);
            addr  = {18'($urandom), 12'(start), 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                send_ar(id, addr, 4'(len), 2'(burst));
                recv_r(id, start, len, burst, 2);
            end else begin
                err_beat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
                send_aw(id, addr, 4'(len), 2'(burst));
                send_w(start, len, burst, err_beat, 1'b0, e);
                recv_b(id, exp_bresp(e));
            end
        end
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++) begin
            sram[w]    = $urandom;
            ref_mem[w] = sram[w];
        end
        mem_rdata = '0;
        rst = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        test_single_read();
        test_incr_read();
        test_wrap_read();
        test_write_burst();
        test_contention();
        test_wlast_err();
        test_reset_mid_burst();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
